pwm_seq_ctrl: RTL and testbench

- Sequencing and configuration controller for the PWM counter.
- Holds double-buffered (shadow/active) period, prescale and direction, and drives them to the counter.
- Commits shadow values only at counter wrap, so the PWM output never glitches mid-period.
- Runs a start / run-N-periods / stop sequence and reports period and done events to the register file.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_wrap_det.sv | 31 +++
 rtl/pwm_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM sequencing controller.
package pwm_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_PSC_W = 8;
    localparam int DEF_REP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        STOPPING
    } pwm_state_e;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] period;
        logic [DEF_PSC_W-1:0] prescale;
        logic                 upnotdown;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_wrap_det.sv
// Counter wrap detector: compares the live count against last cycle's count.
module pwm_wrap_det
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count_val_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             upnotdown_i,
    input  logic             clear_i,
    output logic             wrap_o
);

    logic [CNT_W-1:0] prev_q;

    // Track the counter's synchronous clear so a stale pre-run value never
    // looks like a wrap on the first running cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= clear_i ? '0 : count_val_i;
        end
    end

    assign wrap_o = (prev_q != count_val_i) &&
                    (upnotdown_i ? (count_val_i == '0) : (count_val_i == period_i));

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM sequencing controller: double-buffered config committed at wrap,
// start / run-N-periods / stop sequencing with period and done events.
//
// state    | meaning
// IDLE     | counter disabled, waiting for start
// ARM      | one-cycle synchronous clear of the counter
// RUN      | counting, rep counter active
// STOPPING | counting until the next counted wrap; second stop aborts
module pwm_seq_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PSC_W = DEF_PSC_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [PSC_W-1:0] cfg_prescale,
    input  logic             cfg_upnotdown,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_wr,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] count_val,
    output logic [CNT_W-1:0] cnt_period,
    output logic [PSC_W-1:0] cnt_prescale,
    output logic             cnt_upnotdown,
    output logic             cnt_en,
    output logic             cnt_reset,
    output logic             busy,
    output logic             pending,
    output logic             period_evt,
    output logic             done
);

    pwm_state_e       state_q;
    pwm_cfg_t         active_q;
    pwm_cfg_t         shadow_q;
    logic             pending_q;
    logic [REP_W-1:0] rep_q;
    logic             primed_q;
    logic             en_q;
    logic             clr_q;
    logic             evt_q;
    logic             done_q;

    logic wrap;
    logic running;
    logic zero_per;
    logic counted;
    logic do_commit;
    logic finish;

    pwm_wrap_det #(.CNT_W(CNT_W)) u_wrap_det (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_val_i (count_val),
        .period_i    (active_q.period),
        .upnotdown_i (active_q.upnotdown),
        .clear_i     (clr_q),
        .wrap_o      (wrap)
    );

    assign running   = (state_q == RUN) || (state_q == STOPPING);
    assign zero_per  = (active_q.period == '0);
    assign counted   = running && wrap && primed_q && !zero_per;
    // A zero period never wraps, so a pending commit must not wait for one.
    assign do_commit = pending_q && (counted || (running && zero_per));
    assign finish    = running &&
                       ((counted && ((state_q == STOPPING) || (rep_q == REP_W'(1)))) ||
                        (stop && ((state_q == STOPPING) || zero_per)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            active_q  <= '{period: '0, prescale: '0, upnotdown: 1'b1};
            shadow_q  <= '0;
            pending_q <= 1'b0;
            rep_q     <= '0;
            primed_q  <= 1'b0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            evt_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            evt_q  <= 1'b0;
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        active_q  <= shadow_q;
                        pending_q <= 1'b0;
                        rep_q     <= cfg_reps;
                        primed_q  <= shadow_q.upnotdown;
                        clr_q     <= 1'b1;
                        state_q   <= ARM;
                    end
                end
                ARM: begin
                    en_q    <= 1'b1;
                    state_q <= RUN;
                end
                RUN, STOPPING: begin
                    if (counted) begin
                        evt_q <= 1'b1;
                    end
                    if (counted && (rep_q > REP_W'(1))) begin
                        rep_q <= rep_q - REP_W'(1);
                    end
                    if (wrap && !primed_q) begin
                        primed_q <= 1'b1;
                    end
                    if (do_commit) begin
                        active_q  <= shadow_q;
                        pending_q <= 1'b0;
                    end
                    if (finish) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (stop && (state_q == RUN)) begin
                        state_q <= STOPPING;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Placed last so a coincident write keeps pending set over a commit.
            if (cfg_wr) begin
                shadow_q  <= '{period: cfg_period, prescale: cfg_prescale,
                               upnotdown: cfg_upnotdown};
                pending_q <= 1'b1;
            end
        end
    end

    assign cnt_period    = active_q.period;
    assign cnt_prescale  = active_q.prescale;
    assign cnt_upnotdown = active_q.upnotdown;
    assign cnt_en        = en_q;
    assign cnt_reset     = clr_q;
    assign busy          = (state_q != IDLE);
    assign pending       = pending_q;
    assign period_evt    = evt_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed bench for pwm_seq_ctrl with a simple behavioural PWM counter.
module tb_pwm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_prescale;
    logic        cfg_upnotdown;
    logic [7:0]  cfg_reps;
    logic        cfg_wr;
    logic        start;
    logic        stop;
    logic [15:0] count_val = '0;
    logic [15:0] cnt_period;
    logic [7:0]  cnt_prescale;
    logic        cnt_upnotdown;
    logic        cnt_en;
    logic        cnt_reset;
    logic        busy;
    logic        pending;
    logic        period_evt;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    localparam int W_EVT  = 0;
    localparam int W_DONE = 1;
    localparam int W_CNT  = 2;

    pwm_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_period    (cfg_period),
        .cfg_prescale  (cfg_prescale),
        .cfg_upnotdown (cfg_upnotdown),
        .cfg_reps      (cfg_reps),
        .cfg_wr        (cfg_wr),
        .start         (start),
        .stop          (stop),
        .count_val     (count_val),
        .cnt_period    (cnt_period),
        .cnt_prescale  (cnt_prescale),
        .cnt_upnotdown (cnt_upnotdown),
        .cnt_en        (cnt_en),
        .cnt_reset     (cnt_reset),
        .busy          (busy),
        .pending       (pending),
        .period_evt    (period_evt),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Counter model, one tick per clock (prescale not modelled).
    always @(posedge clk) begin
        if (cnt_reset)
            count_val <= '0;
        else if (cnt_en) begin
            if (cnt_upnotdown)
                count_val <= (count_val >= cnt_period) ? 16'd0 : count_val + 16'd1;
            else
                count_val <= (count_val == 16'd0) ? cnt_period : count_val - 16'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [15:0] p, input logic [7:0] ps, input logic up,
                       input logic [7:0] r);
        cfg_period    = p;
        cfg_prescale  = ps;
        cfg_upnotdown = up;
        cfg_reps      = r;
        cfg_wr        = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Returns the number of negedges until the condition holds, or -1.
    task automatic wait_for(input int sel, input logic [15:0] val, input int max,
                            output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if ((sel == W_EVT && period_evt) || (sel == W_DONE && done) ||
                (sel == W_CNT && count_val == val)) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_period = '0; cfg_prescale = '0; cfg_upnotdown = 1'b1; cfg_reps = '0;
        cfg_wr = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", cnt_period, 0);
        chk("rst_dir", cnt_upnotdown, 1);
        chk("rst_en", cnt_en, 0);
        chk("rst_clr", cnt_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_evt", period_evt, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic up run: period 3, two periods
        cfg(16'd3, 8'd0, 1'b1, 8'd2);
        chk("up_pending", pending, 1);
        pulse_start();
        chk("up_arm_clr", cnt_reset, 1);
        chk("up_arm_en", cnt_en, 0);
        chk("up_arm_busy", busy, 1);
        chk("up_arm_period", cnt_period, 3);
        chk("up_arm_pending", pending, 0);
        @(negedge clk);
        chk("up_run_en", cnt_en, 1);
        chk("up_run_clr", cnt_reset, 0);
        chk("up_run_cnt", count_val, 0);
        wait_for(W_EVT, 16'd0, 20, n);
        chk("up_evt1_lat", n, 5);
        chk("up_evt1_cnt", count_val, 1);
        chk("up_evt1_done", done, 0);
        @(negedge clk);
        chk("up_evt_pulse", period_evt, 0);
        wait_for(W_DONE, 16'd0, 20, n);
        chk("up_done_lat", n, 3);
        chk("up_done_evt", period_evt, 1);
        chk("up_done_busy", busy, 0);
        chk("up_done_en", cnt_en, 0);
        @(negedge clk);
        chk("up_done_pulse", done, 0);

        // Safe update: period 5 continuous, new period 2 written at count 2
        cfg(16'd5, 8'd0, 1'b1, 8'd0);
        pulse_start();
        wait_for(W_CNT, 16'd2, 10, n);
        chk("su_reach2", n, 3);
        cfg(16'd2, 8'd0, 1'b1, 8'd0);
        chk("su_pending", pending, 1);
        chk("su_hold5", cnt_period, 5);
        pulse_start();
        chk("su_start_ign", cnt_reset, 0);
        chk("su_start_busy", busy, 1);
        wait_for(W_CNT, 16'd5, 5, n);
        chk("su_reach5", n, 1);
        chk("su_at5", cnt_period, 5);
        @(negedge clk);
        chk("su_wrap_cnt", count_val, 0);
        chk("su_wrap_hold", cnt_period, 5);
        chk("su_wrap_pend", pending, 1);
        @(negedge clk);
        chk("su_commit", cnt_period, 2);
        chk("su_commit_pend", pending, 0);
        chk("su_commit_evt", period_evt, 1);
        pulse_stop();
        pulse_stop();
        chk("su_abort_done", done, 1);
        chk("su_abort_busy", busy, 0);

        // Down mode: first 0->4 load is not counted
        cfg(16'd4, 8'd0, 1'b0, 8'd1);
        pulse_start();
        chk("dn_dir", cnt_upnotdown, 0);
        @(negedge clk);
        wait_for(W_EVT, 16'd0, 20, n);
        chk("dn_evt_lat", n, 7);
        chk("dn_done", done, 1);
        chk("dn_busy", busy, 0);

        // Graceful stop at count 2
        cfg(16'd7, 8'd0, 1'b1, 8'd0);
        pulse_start();
        wait_for(W_CNT, 16'd2, 10, n);
        chk("st_reach2", n, 3);
        pulse_stop();
        chk("st_busy", busy, 1);
        wait_for(W_DONE, 16'd0, 20, n);
        chk("st_done_lat", n, 6);
        chk("st_done_evt", period_evt, 1);
        chk("st_done_en", cnt_en, 0);

        // Second stop aborts
        pulse_start();
        wait_for(W_CNT, 16'd2, 10, n);
        chk("ab_reach2", n, 3);
        pulse_stop();
        chk("ab_cnt3", count_val, 3);
        pulse_stop();
        chk("ab_done", done, 1);
        chk("ab_en", cnt_en, 0);
        chk("ab_busy", busy, 0);

        // Reset mid-run at count 4
        pulse_start();
        wait_for(W_CNT, 16'd4, 12, n);
        chk("mr_reach4", n, 5);
        chk("mr_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_en", cnt_en, 0);
        chk("mr_busy0", busy, 0);
        chk("mr_period", cnt_period, 0);
        chk("mr_dir", cnt_upnotdown, 1);
        chk("mr_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mr_no_done", done, 0);
        chk("mr_idle", busy, 0);

        // Zero period: start+stop together (start wins), then stop ends at once
        cfg(16'd0, 8'd2, 1'b1, 8'd0);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("zp_arm", cnt_reset, 1);
        chk("zp_psc", cnt_prescale, 2);
        @(negedge clk);
        chk("zp_en", cnt_en, 1);
        pulse_stop();
        chk("zp_stop_done", done, 1);
        chk("zp_stop_busy", busy, 0);

        // Zero period: pending write commits without a wrap
        pulse_start();
        @(negedge clk);
        chk("zc_cnt0", count_val, 0);
        cfg(16'd6, 8'd0, 1'b1, 8'd0);
        chk("zc_pending", pending, 1);
        chk("zc_hold0", cnt_period, 0);
        @(negedge clk);
        chk("zc_commit", cnt_period, 6);
        chk("zc_commit_pend", pending, 0);
        chk("zc_no_evt", period_evt, 0);
        wait_for(W_EVT, 16'd0, 20, n);
        chk("zc_evt_lat", n, 8);
        pulse_stop();
        pulse_stop();
        chk("zc_abort_done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
